// File: rtl/dlt_sweep_seq.sv
// Stimulus sequencer and golden checker for the 32-instance CC_DLT constant-gate latch array.
// Optional first-failure capture ports are enabled by defining DLT_SEQ_FIRST_FAIL_EN.
module dlt_sweep_seq #(
  parameter int unsigned NUM_VECTORS   = 64,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      q,
  output logic             d,
  output logic             sr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      step
`ifdef DLT_SEQ_FIRST_FAIL_EN
  ,
  output logic [15:0]      fail_step,
  output logic [31:0]      fail_mask
`endif
);

  localparam int unsigned CntW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [15:0] LastStep = 16'(NUM_VECTORS - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } state_e;

  state_e           state_q;
  logic [15:0]      lfsr_q;
  logic [CntW-1:0]  cnt_q;
  logic [31:0]      model_q, known_q;
  logic             d_q, sr_q, busy_q, done_q;
  logic [ERR_W-1:0] err_q;
  logic [15:0]      step_q;
`ifdef DLT_SEQ_FIRST_FAIL_EN
  logic             fail_seen_q;
  logic [15:0]      fail_step_q;
  logic [31:0]      fail_mask_q;
`endif

  logic [15:0]      lfsr_next;
  logic             d_next, sr_next;
  logic [31:0]      model_d, known_d;
  logic [31:0]      mism;
  logic [ERR_W-1:0] err_inc;

  always_comb begin
    lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
    d_next    = lfsr_next[0];
    sr_next   = lfsr_next[1] & lfsr_next[2];
  end

  // Bit k = 2i+j: i[0]=k[1], i[1]=k[2], i[2]=k[3]; gate tied to j=k[0].
  always_comb begin
    model_d = model_q;
    known_d = known_q;
    for (int k = 0; k < 32; k++) begin
      if (sr_next ^ k[2]) begin
        model_d[k] = k[3];
        known_d[k] = 1'b1;
      end else if (k[0] ^ k[1]) begin
        model_d[k] = d_next;
        known_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    mism    = (q ^ model_q) & known_q;
    err_inc = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lfsr_q      <= 16'h0000;
      cnt_q       <= '0;
      model_q     <= 32'h0;
      known_q     <= 32'h0;
      d_q         <= 1'b0;
      sr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      step_q      <= 16'h0000;
`ifdef DLT_SEQ_FIRST_FAIL_EN
      fail_seen_q <= 1'b0;
      fail_step_q <= 16'h0000;
      fail_mask_q <= 32'h0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // Load values are registered on the accepting edge so busy rises next cycle.
          if (start) begin
            state_q     <= StLoad;
            lfsr_q      <= LFSR_SEED;
            step_q      <= 16'h0000;
            err_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
`ifdef DLT_SEQ_FIRST_FAIL_EN
            fail_seen_q <= 1'b0;
            fail_step_q <= 16'h0000;
            fail_mask_q <= 32'h0;
`endif
          end
        end
        StLoad: begin
          state_q <= StDrive;
        end
        StDrive: begin
          lfsr_q  <= lfsr_next;
          d_q     <= d_next;
          sr_q    <= sr_next;
          model_q <= model_d;
          known_q <= known_d;
          cnt_q   <= '0;
          state_q <= StSettle;
        end
        StSettle: begin
          if (cnt_q == LastCnt) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCheck: begin
          if (mism != 32'h0) begin
            err_q <= err_inc;
`ifdef DLT_SEQ_FIRST_FAIL_EN
            if (!fail_seen_q) begin
              fail_seen_q <= 1'b1;
              fail_step_q <= step_q;
              fail_mask_q <= mism;
            end
`endif
          end
          if (step_q == LastStep) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            step_q  <= step_q + 16'd1;
            state_q <= StDrive;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign d       = d_q;
  assign sr      = sr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = done_q & (err_q == '0);
  assign err_cnt = err_q;
  assign step    = step_q;
`ifdef DLT_SEQ_FIRST_FAIL_EN
  assign fail_step = fail_step_q;
  assign fail_mask = fail_mask_q;
`endif

endmodule

// File: tb/tb_dlt_sweep_seq.sv
// Directed bench for dlt_sweep_seq against a behavioural CC_DLT latch array.
// Covers DLT_SEQ_FIRST_FAIL_EN capture ports when that macro is defined.
module tb_dlt_sweep_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic inv5 = 1'b0;
  logic poke = 1'b0;

  // Latch power-up contents: INIT = i[3] for bit k = 2i+j.
  logic [31:0] lat = 32'hFFFF0000;
  logic [31:0] lat2 = 32'hFFFF0000;
  logic [31:0] q, q2;

  logic        d, sr, busy, done, pass;
  logic [7:0]  err_cnt;
  logic [15:0] step;
  logic        d2, sr2, busy2, done2, pass2;
  logic [1:0]  err2;
  logic [15:0] step2;
`ifdef DLT_SEQ_FIRST_FAIL_EN
  logic [15:0] fail_step, fail_step2;
  logic [31:0] fail_mask, fail_mask2;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // CC_DLT instance (i,j): G_INV=i[0], SR_INV=i[1], SR_VAL=i[2], gate tied to j.
  function automatic logic [31:0] latch_eval(input logic [31:0] cur, input logic dv,
                                             input logic srv);
    logic [31:0] nxt;
    nxt = cur;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (srv != i[1]) nxt[2*i+j] = i[2];
        else if (j[0] != i[0]) nxt[2*i+j] = dv;
      end
    end
    return nxt;
  endfunction

  always @(d or sr or poke) begin
    if (poke) lat = 32'hFFFFFFFF;
    else lat = latch_eval(lat, d, sr);
  end

  always @(d2 or sr2) lat2 = latch_eval(lat2, d2, sr2);

  assign q  = lat ^ (inv5 ? 32'h00000020 : 32'h0);
  assign q2 = ~lat2;

  dlt_sweep_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .q        (q),
    .d        (d),
    .sr       (sr),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .step     (step)
`ifdef DLT_SEQ_FIRST_FAIL_EN
    ,
    .fail_step(fail_step),
    .fail_mask(fail_mask)
`endif
  );

  dlt_sweep_seq #(
    .NUM_VECTORS  (8),
    .SETTLE_CYCLES(1),
    .ERR_W        (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .q        (q2),
    .d        (d2),
    .sr       (sr2),
    .busy     (busy2),
    .done     (done2),
    .pass     (pass2),
    .err_cnt  (err2),
    .step     (step2)
`ifdef DLT_SEQ_FIRST_FAIL_EN
    ,
    .fail_step(fail_step2),
    .fail_mask(fail_mask2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge after the sampling edge E0, cyc = 0.
  task automatic pulse(input bit second);
    @(negedge clk);
    if (second) start2 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
    cyc    = 0;
  endtask

  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [1:0] exp_ds [6];

  initial begin
    exp_ds = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10};

    // T1 reset state
    #1;
    chk("t1_ctl", {27'h0, d, sr, busy, done, pass}, 32'h0);
    chk("t1_err", {24'h0, err_cnt}, 32'h0);
    chk("t1_step", {16'h0, step}, 32'h0);
    chk("t1_err2", {30'h0, err2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T2 clean run
    pulse(1'b0);
    chk("t2_busy", {31'h0, busy}, 32'h1);
    chk("t2_done_lo", {31'h0, done}, 32'h0);
    for (int v = 0; v < 6; v++) begin
      adv_to(4 + 6 * v);
      chk("t2_dsr", {30'h0, d, sr}, {30'h0, exp_ds[v]});
      chk("t2_step", {16'h0, step}, v);
    end
    adv_to(384);
    chk("t2_done_early", {30'h0, busy, done}, 32'h2);
    adv_to(385);
    chk("t2_done", {29'h0, busy, done, pass}, 32'h3);
    chk("t2_err", {24'h0, err_cnt}, 32'h0);
    chk("t2_step_end", {16'h0, step}, 32'd63);

    // T3 stuck bit 5
    inv5 = 1'b1;
    pulse(1'b0);
    chk("t3_restart", {30'h0, busy, done}, 32'h2);
    adv_to(385);
    chk("t3_done", {29'h0, busy, done, pass}, 32'h2);
    chk("t3_err", {24'h0, err_cnt}, 32'd64);
`ifdef DLT_SEQ_FIRST_FAIL_EN
    chk("t3_fail_mask", fail_mask, 32'h00000020);
    chk("t3_fail_step", {16'h0, fail_step}, 32'h0);
`endif
    inv5 = 1'b0;

    // T4 saturation on the ERR_W=2 instance
    pulse(1'b1);
    adv_to(4);
    chk("t4_err_v0", {30'h0, err2}, 32'd1);
    adv_to(7);
    chk("t4_err_v1", {30'h0, err2}, 32'd2);
    adv_to(10);
    chk("t4_err_v2", {30'h0, err2}, 32'd3);
    adv_to(13);
    chk("t4_err_sat", {30'h0, err2}, 32'd3);
    adv_to(24);
    chk("t4_done_early", {31'h0, done2}, 32'h0);
    adv_to(25);
    chk("t4_done", {29'h0, busy2, done2, pass2}, 32'h2);
    chk("t4_err_end", {30'h0, err2}, 32'd3);
    chk("t4_step_end", {16'h0, step2}, 32'd7);

    // T5 start while busy is ignored
    pulse(1'b0);
    adv_to(63);
    chk("t5_step10", {16'h0, step}, 32'd10);
    start = 1'b1;
    adv_to(64);
    start = 1'b0;
    chk("t5_still_busy", {30'h0, busy, done}, 32'h2);
    adv_to(384);
    chk("t5_done_early", {31'h0, done}, 32'h0);
    adv_to(385);
    chk("t5_done", {29'h0, busy, done, pass}, 32'h3);
    chk("t5_err", {24'h0, err_cnt}, 32'h0);
    chk("t5_step_end", {16'h0, step}, 32'd63);

    // T6 asynchronous reset mid-run, then a rerun with known cleared
    pulse(1'b0);
    adv_to(123);
    chk("t6_step20", {16'h0, step}, 32'd20);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_ctl", {27'h0, d, sr, busy, done, pass}, 32'h0);
    chk("t6_rst_err", {24'h0, err_cnt}, 32'h0);
    chk("t6_rst_step", {16'h0, step}, 32'h0);
    poke = 1'b1;
    #1 poke = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b0);
    adv_to(7);
    chk("t6_first_check", {24'h0, err_cnt}, 32'h0);
    chk("t6_step1", {16'h0, step}, 32'd1);
    adv_to(385);
    chk("t6_done", {29'h0, busy, done, pass}, 32'h3);
    chk("t6_err", {24'h0, err_cnt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
